// File: rtl/prover_eval_cubic_pkg.sv
// -----------------------------------------------------------------------------
// prover_eval_cubic_pkg
// Field definitions shared by the cubic evaluator and its arithmetic units.
//   F_NBITS : width of one field element
//   P       : field modulus, 2^32 - 5 (prime)
//   add_mod : (a + b) mod P for reduced operands a, b in [0, P)
// -----------------------------------------------------------------------------
package prover_eval_cubic_pkg;

  localparam int unsigned        F_NBITS = 32;
  localparam logic [F_NBITS-1:0] P       = 32'hFFFF_FFFB;

  // Operands are already reduced, so the raw sum is below 2P and one
  // conditional subtraction brings it back into [0, P).
  function automatic logic [F_NBITS-1:0] add_mod(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] sum;
    // NOTE: inside a function, blocking assignments are correct; the caller
    // decides whether the result lands in a flop (<=) or a net.
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, P}) sum = sum - {1'b0, P};
    return sum[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/prover_eval_cubic_field.sv
// -----------------------------------------------------------------------------
// field_adder / field_multiplier
// The two GF(P) arithmetic units shared by the Horner evaluator.
//
// field_adder
//   clk, rstb : clock, asynchronous active-low reset
//   en        : 1-cycle request; out = (a + b) mod P on the following cycle
//   a, b      : reduced operands
//   out       : registered result
//   ready     : always 1 (single-cycle unit, accepts every cycle)
//
// field_multiplier
//   clk, rstb : clock, asynchronous active-low reset
//   en        : 1-cycle request, accepted only while ready = 1
//   a, b      : reduced operands, captured on acceptance
//   out       : registered (a * b) mod P, valid once ready returns high
//   ready     : low for F_NBITS cycles after acceptance
// -----------------------------------------------------------------------------
module field_adder
  import prover_eval_cubic_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] out,
  output logic               ready
);

  assign ready = 1'b1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out <= '0;
    end else if (en) begin
      out <= add_mod(a, b);
    end
  end

endmodule

module field_multiplier
  import prover_eval_cubic_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] out,
  output logic               ready
);

  localparam int unsigned CNT_W = $clog2(F_NBITS + 1);

  logic [F_NBITS-1:0] a_reg;
  logic [F_NBITS-1:0] b_reg;
  logic [F_NBITS-1:0] acc;
  logic [F_NBITS-1:0] acc_next;
  logic [CNT_W-1:0]   cnt;

  // MSB-first double-and-add: acc = 2*acc + bit*a, each term reduced mod P.
  always_comb begin
    // NOTE: every variable written in always_comb gets a value on every path
    // (here a single unconditional assignment), otherwise a latch is inferred.
    acc_next = add_mod(add_mod(acc, acc), b_reg[F_NBITS-1] ? a_reg : '0);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: operand and working registers are reset too, so a reset in the
      // middle of a product leaves no stale partial result behind.
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
      ready <= 1'b1;
    end else if (ready) begin
      if (en) begin
        a_reg <= a;
        b_reg <= b;
        acc   <= '0;
        cnt   <= CNT_W'(F_NBITS);
        ready <= 1'b0;
      end
    end else begin
      acc   <= acc_next;
      b_reg <= b_reg << 1;
      cnt   <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        out   <= acc_next;
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prover_eval_cubic.sv
// -----------------------------------------------------------------------------
// prover_eval_cubic
// Evaluates the sumcheck round polynomial f(r) = c0 + c1 r + c2 r^2 + c3 r^3
// over GF(P) by Horner's rule with one shared multiplier and one adder.
//
// Parameter CUBIC : 1 = cubic (c3..c0), 0 = quadratic (c_in[3] ignored).
// Optional macro EVAL_SUM_CHECK_EN : adds claim_in/check_ok and checks
//   f(0) + f(1) = 2c0 + c1 + c2 (+ c3) against the claim using idle adder
//   cycles during the multiplications.
//
// Ports
//   clk, rstb   : clock, asynchronous active-low reset
//   en          : rising edge starts an evaluation (ignored while busy)
//   c_in        : coefficients, c_in[k] multiplies r^k
//   r_in        : evaluation point (reduced field element)
//   val_out     : registered f(r), updated only on completion
//   ready       : idle and no start this cycle
//   ready_pulse : one-cycle pulse when ready rises
//   claim_in    : (EVAL_SUM_CHECK_EN) claimed f(0)+f(1), latched on start
//   check_ok    : (EVAL_SUM_CHECK_EN) sum matched claim, updated with val_out
// -----------------------------------------------------------------------------
module prover_eval_cubic
  import prover_eval_cubic_pkg::*;
#(
  parameter bit CUBIC = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic [3:0][F_NBITS-1:0] c_in,
  input  logic [F_NBITS-1:0]     r_in,
  output logic [F_NBITS-1:0]     val_out,
  output logic                   ready,
  output logic                   ready_pulse
`ifdef EVAL_SUM_CHECK_EN
  ,
  input  logic [F_NBITS-1:0]     claim_in,
  output logic                   check_ok
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL3,
    ST_ADD2,
    ST_MUL2,
    ST_ADD1,
    ST_MUL1,
    ST_ADD0
  } state_t;

  // c3 is only needed after start when the sum check consumes it.
`ifdef EVAL_SUM_CHECK_EN
  localparam int unsigned C_REGS = 4;
`else
  localparam int unsigned C_REGS = 3;
`endif

  state_t                         state;
  logic                           en_dly;
  logic                           ready_dly;
  logic [C_REGS-1:0][F_NBITS-1:0] c_reg;
  logic [F_NBITS-1:0]             r_reg;
  logic [F_NBITS-1:0]             acc;      // Horner accumulator = multiplier operand a
  logic [F_NBITS-1:0]             add_a;
  logic [F_NBITS-1:0]             add_b;
  logic                           mul_en;
  logic                           add_en;

  logic [F_NBITS-1:0]             mul_out;
  logic [F_NBITS-1:0]             add_out;
  logic                           mul_ready;
  logic                           add_ready;

  logic                           start;
  logic                           mul_ok;
  logic                           add_ok;
  logic                           mul_adv;
  logic                           s_done;

  assign start       = en & ~en_dly;
  assign ready       = (state == ST_IDLE) & ~start;
  assign ready_pulse = ready & ~ready_dly;

  // A unit's result is usable once it reports ready and no request of ours
  // is still sitting in its enable register.
  assign mul_ok = mul_ready & ~mul_en;
  assign add_ok = add_ready & ~add_en;

  field_multiplier u_mul (
    .clk   (clk),
    .rstb  (rstb),
    .en    (mul_en),
    .a     (acc),
    .b     (r_reg),
    .out   (mul_out),
    .ready (mul_ready)
  );

  field_adder u_add (
    .clk   (clk),
    .rstb  (rstb),
    .en    (add_en),
    .a     (add_a),
    .b     (add_b),
    .out   (add_out),
    .ready (add_ready)
  );

`ifdef EVAL_SUM_CHECK_EN
  // s accumulates 2c0 + c1 + c2 (+ c3): start at c0, then add c0, c1, c2, c3.
  localparam logic [2:0] S_ADDS = CUBIC ? 3'd4 : 3'd3;

  logic [F_NBITS-1:0] s_acc;
  logic [F_NBITS-1:0] claim_reg;
  logic [2:0]         s_step;
  logic               s_pending;
  logic               in_mul;
  logic               s_issue;

  assign in_mul  = (state == ST_MUL3) | (state == ST_MUL2) | (state == ST_MUL1);
  // Borrow the adder only while a multiplication is still running, so the
  // Horner add that follows it never collides with a sum-check add.
  assign s_issue = in_mul & ~mul_ok & add_ok & ~s_pending & (s_step != S_ADDS);
  assign mul_adv = mul_ok & ~s_pending;
  assign s_done  = (s_step == S_ADDS) & ~s_pending;
`else
  assign mul_adv = mul_ok;
  assign s_done  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_IDLE;
      en_dly    <= 1'b1;   // en already high at reset release is not an edge
      ready_dly <= 1'b1;
      val_out   <= '0;
      c_reg     <= '0;
      r_reg     <= '0;
      acc       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      mul_en    <= 1'b0;
      add_en    <= 1'b0;
`ifdef EVAL_SUM_CHECK_EN
      s_acc     <= '0;
      claim_reg <= '0;
      s_step    <= '0;
      s_pending <= 1'b0;
      check_ok  <= 1'b0;
`endif
    end else begin
      en_dly    <= en;
      ready_dly <= ready;
      // Enables are single-cycle pulses unless re-asserted below.
      mul_en    <= 1'b0;
      add_en    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            c_reg  <= c_in[C_REGS-1:0];
            r_reg  <= r_in;
            acc    <= CUBIC ? c_in[3] : c_in[2];
            mul_en <= 1'b1;
            state  <= CUBIC ? ST_MUL3 : ST_MUL2;
`ifdef EVAL_SUM_CHECK_EN
            s_acc     <= c_in[0];
            s_step    <= '0;
            claim_reg <= claim_in;
`endif
          end
        end
        ST_MUL3: begin
          if (mul_adv) begin
            add_a  <= mul_out;
            add_b  <= c_reg[2];
            add_en <= 1'b1;
            state  <= ST_ADD2;
          end
        end
        ST_ADD2: begin
          if (add_ok) begin
            acc    <= add_out;
            mul_en <= 1'b1;
            state  <= ST_MUL2;
          end
        end
        ST_MUL2: begin
          if (mul_adv) begin
            add_a  <= mul_out;
            add_b  <= c_reg[1];
            add_en <= 1'b1;
            state  <= ST_ADD1;
          end
        end
        ST_ADD1: begin
          if (add_ok) begin
            acc    <= add_out;
            mul_en <= 1'b1;
            state  <= ST_MUL1;
          end
        end
        ST_MUL1: begin
          if (mul_adv) begin
            add_a  <= mul_out;
            add_b  <= c_reg[0];
            add_en <= 1'b1;
            state  <= ST_ADD0;
          end
        end
        ST_ADD0: begin
          if (add_ok && s_done) begin
            val_out <= add_out;
            state   <= ST_IDLE;
`ifdef EVAL_SUM_CHECK_EN
            check_ok <= (s_acc == claim_reg);
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase

`ifdef EVAL_SUM_CHECK_EN
      if (s_issue) begin
        add_a     <= s_acc;
        add_b     <= c_reg[s_step[1:0]];
        add_en    <= 1'b1;
        s_pending <= 1'b1;
      end
      if (s_pending && add_ok) begin
        s_acc     <= add_out;
        s_step    <= s_step + 3'd1;
        s_pending <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prover_eval_cubic.sv
// -----------------------------------------------------------------------------
// tb_prover_eval_cubic
// Directed bench for prover_eval_cubic. A cubic instance and a quadratic
// instance share all inputs, so each vector checks both f(r) and the
// quadratic truncation 1..c2 against hand-computed values, plus the
// start-to-ready latency, ready_pulse count, busy-time start rejection and
// asynchronous reset behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prover_eval_cubic;
  import prover_eval_cubic_pkg::*;

  // Latency in ready-low cycles: multiplier = enable cycle + one per bit,
  // adder = enable cycle only.
  localparam int LMUL  = F_NBITS + 1;
  localparam int LADD  = 1;
  localparam int LAT_C = 3 * (LMUL + LADD) + 7;
  localparam int LAT_Q = 2 * (LMUL + LADD) + 5;

  localparam logic [F_NBITS-1:0] PM1 = 32'hFFFF_FFFA;  // p-1
  localparam logic [F_NBITS-1:0] PM2 = 32'hFFFF_FFF9;  // p-2

  logic                    clk;
  logic                    rstb;
  logic                    en;
  logic [3:0][F_NBITS-1:0] c_in;
  logic [F_NBITS-1:0]      r_in;
  logic [F_NBITS-1:0]      val_c, val_q;
  logic                    rdy_c, rdy_q, rp_c, rp_q;
`ifdef EVAL_SUM_CHECK_EN
  logic [F_NBITS-1:0]      claim_in;
  logic                    ok_c, ok_q;
`endif

  int checks = 0;
  int errors = 0;

  prover_eval_cubic #(.CUBIC(1'b1)) dut_c (
    .clk         (clk),
    .rstb        (rstb),
    .en          (en),
    .c_in        (c_in),
    .r_in        (r_in),
    .val_out     (val_c),
    .ready       (rdy_c),
    .ready_pulse (rp_c)
`ifdef EVAL_SUM_CHECK_EN
    ,
    .claim_in    (claim_in),
    .check_ok    (ok_c)
`endif
  );

  prover_eval_cubic #(.CUBIC(1'b0)) dut_q (
    .clk         (clk),
    .rstb        (rstb),
    .en          (en),
    .c_in        (c_in),
    .r_in        (r_in),
    .val_out     (val_q),
    .ready       (rdy_q),
    .ready_pulse (rp_q)
`ifdef EVAL_SUM_CHECK_EN
    ,
    .claim_in    (claim_in),
    .check_ok    (ok_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [F_NBITS-1:0] obs,
                       input logic [F_NBITS-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts one evaluation on a negedge and follows it to completion,
  // sampling every cycle on the falling edge.
  task automatic run_eval(input string tag,
                          input logic [F_NBITS-1:0] c0, c1, c2, c3, r,
                          input logic [F_NBITS-1:0] exp_c, exp_q,
                          input logic [F_NBITS-1:0] claim,
                          input logic exp_ok_c, exp_ok_q,
                          input bit disturb);
    int lc, lq, pc, pq;
    bit done, stay;
    @(negedge clk);
    c_in = {c3, c2, c1, c0};
    r_in = r;
`ifdef EVAL_SUM_CHECK_EN
    claim_in = claim;
`endif
    en = 1'b1;
    #1;
    check({tag, " start_ready_c"}, rdy_c, 1'b0);
    lc = 1; lq = 1; pc = 0; pq = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!rdy_c) lc++;
      if (!rdy_q) lq++;
      pc += int'(rp_c);
      pq += int'(rp_q);
      if (rdy_c && rdy_q) done = 1'b1;
      // New operands and a fresh en edge while busy must change nothing.
      if (disturb && i == 10) begin
        c_in = {4{32'd7}};
        r_in = 32'd5;
        en   = 1'b0;
      end
      if (disturb && i == 11) en = 1'b1;
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " val_c"}, val_c, exp_c);
    check({tag, " val_q"}, val_q, exp_q);
    check({tag, " lat_c"}, lc, LAT_C);
    check({tag, " lat_q"}, lq, LAT_Q);
    check({tag, " pulses_c"}, pc, 1);
    check({tag, " pulses_q"}, pq, 1);
`ifdef EVAL_SUM_CHECK_EN
    check({tag, " check_ok_c"}, ok_c, exp_ok_c);
    check({tag, " check_ok_q"}, ok_q, exp_ok_q);
`endif
    if (disturb) begin
      // en stays high after completion: a level, not an edge, so no restart.
      stay = 1'b1;
      repeat (5) begin
        @(negedge clk);
        stay &= rdy_c & rdy_q;
      end
      check({tag, " no_restart"}, stay, 1'b1);
      check({tag, " val_c_hold"}, val_c, exp_c);
    end
    en = 1'b0;
  endtask

  initial begin
    bit any_low;
    rstb = 1'b0;
    en   = 1'b0;
    c_in = '0;
    r_in = '0;
`ifdef EVAL_SUM_CHECK_EN
    claim_in = '0;
`endif
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    check("reset val_c", val_c, '0);
    check("reset val_q", val_q, '0);
    check("reset ready_c", rdy_c, 1'b1);
    check("reset ready_q", rdy_q, 1'b1);
    check("reset pulse_c", rp_c, 1'b0);

    // c = {1,2,3,4}: f = 1+2r+3r^2+4r^3, g = 1+2r+3r^2.
    // Sums f(0)+f(1) = 11 (cubic), 7 (quadratic).
    run_eval("r2",   1, 2, 3, 4, 2,   49,  17, 11, 1'b1, 1'b0, 1'b0);
    run_eval("rm1",  1, 2, 3, 4, PM1, PM2, 2,  12, 1'b0, 1'b0, 1'b0);
    run_eval("r0",   1, 2, 3, 4, 0,   1,   1,  7,  1'b0, 1'b1, 1'b0);
    run_eval("r1",   1, 2, 3, 4, 1,   10,  6,  11, 1'b1, 1'b0, 1'b0);
    // c = {5,0,1,99}, r = 3: g = 5+9 = 14, f = 14 + 99*27 = 2687.
    run_eval("quad", 5, 0, 1, 99, 3,  2687, 14, 0, 1'b0, 1'b0, 1'b0);
    // All coefficients -1 at r = -1: f = -1+1-1+1 = 0, g = -1.
    run_eval("allm1", PM1, PM1, PM1, PM1, PM1, 0, PM1, 0, 1'b0, 1'b0, 1'b0);
    run_eval("busy", 1, 2, 3, 4, 2,   49,  17, 11, 1'b1, 1'b0, 1'b1);

    // Reset during MUL2 of the cubic run (cycles ~37..70 after start).
    @(negedge clk);
    c_in = {32'd4, 32'd3, 32'd2, 32'd1};
    r_in = 32'd2;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (48) @(negedge clk);
    check("mid busy_c", rdy_c, 1'b0);
    check("mid hold_c", val_c, 49);
    #2 rstb = 1'b0;
    #1;
    check("async val_c", val_c, '0);
    check("async ready_c", rdy_c, 1'b1);
    check("async val_q", val_q, '0);
    @(negedge clk);
    rstb = 1'b1;
    run_eval("after_rst", 1, 2, 3, 4, 2, 49, 17, 11, 1'b1, 1'b0, 1'b0);

    // en held high through reset release must not start an evaluation.
    @(negedge clk);
    en   = 1'b1;
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    any_low = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (!rdy_c || !rdy_q) any_low = 1'b1;
    end
    check("en_held no_start", any_low, 1'b0);
    check("en_held val_c", val_c, '0);
    en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prover_eval_cubic.md
Name: prover_eval_cubic

Overview:
Downstream neighbour of the sumcheck interpolator. Takes the 4 coefficients c0..c3 of the round polynomial and the verifier challenge r. Evaluates f(r) = c0 + c1*r + c2*r^2 + c3*r^3 in GF(p) by Horner's rule, using one field_multiplier and one field_adder. The result is the claimed value carried into the next sumcheck round.

Parameters:
CUBIC, 1, 1 = cubic (4 coefficients); 0 = quadratic (c_in[3] ignored, Horner starts at c2).

Ports:
clk  input  1  clock
rstb  input  1  asynchronous active-low reset
en  input  1  start request; rising edge starts an evaluation
c_in  input  [`F_NBITS-1:0] x4 (c_in[3:0])  coefficients, index = power of x
r_in  input  `F_NBITS  evaluation point (field element, < p)
val_out  output  `F_NBITS  f(r), registered
ready  output  1  idle and no start this cycle
ready_pulse  output  1  one-cycle pulse on rising edge of ready
check_ok  output  1  only with EVAL_SUM_CHECK_EN (see Optional Feature)
claim_in  input  `F_NBITS  only with EVAL_SUM_CHECK_EN

Behaviour:
- Reset: rstb is asynchronous, active-low; clock is clk.
- Reset values: val_out=0, state=ST_IDLE, en_dly=1, ready_dly=1, all internal operand regs=0, sub-unit enables=0. Hence ready=1 and ready_pulse=0 out of reset.
- start = en & ~en_dly. A held-high en at reset deassertion does not start.
- ready = (state==ST_IDLE) & ~start.
- ready_pulse = ready & ~ready_dly.
- On start: latch c_in[3:0] and r_in into internal registers; inputs may change afterwards.
- Start edges while busy are ignored (no queueing).
- Sub-unit handshake:
  - An enable is a 1-cycle pulse from a register.
  - A unit is usable when its ready=1 and its enable reg=0 (mul_ok, add_ok).
  - Each state advances only when the unit it consumes is ok.
- States, acc = accumulator reg:
  - ST_IDLE: on start, acc <- c3 (CUBIC=1) or c2 (CUBIC=0); issue mul(acc_src, r); go to MUL3 or MUL2 respectively.
  - MUL3: mul_ok -> add(mul_out, c2) -> ADD2.
  - ADD2: add_ok -> mul(add_out, r) -> MUL2.
  - MUL2: mul_ok -> add(mul_out, c1) -> ADD1.
  - ADD1: add_ok -> mul(add_out, r) -> MUL1.
  - MUL1: mul_ok -> add(mul_out, c0) -> ADD0.
  - ADD0: add_ok -> val_out <- add_out -> ST_IDLE.
- val_out changes only in the ADD0->IDLE transition. It holds its value until the next completion.
- Latency from start to ready: 3*(Lmul+Ladd) + 7 cycles for cubic, 2*(Lmul+Ladd) + 5 for quadratic, where Lmul/Ladd are the unit latencies including the enable-register cycle.
- Arithmetic: all values are reduced field elements in [0,p). No negation is required. Out-of-range inputs are undefined.
- Reset mid-operation: immediately returns to ST_IDLE, val_out=0. In-flight unit results are discarded because the units are also reset.
- r=0 yields c0; r=1 yields sum of the coefficients mod p.

Optional Feature:
- Macro EVAL_SUM_CHECK_EN.
- When defined:
  - Adds claim_in (latched at start) and check_ok output.
  - During otherwise-idle adder cycles, computes s = 2*c0 + c1 + c2 + c3 (c3 omitted if CUBIC=0), i.e. f(0)+f(1). This reuses the adder in the MUL states and needs extra states only if the adds do not fit.
  - check_ok <- (s == claim_in) on the same cycle val_out updates; reset value 0.
  - Total latency grows by at most 2 adder operations.
- When undefined: ports claim_in/check_ok are absent; behaviour is exactly as above.

Decomposition:
- `F_NBITS, p and the field constants stay in field_arith_defs.v.
- State enum is local to this module.
- Arithmetic reuses field_adder and field_multiplier instances (one each). No new sub-module is needed.
- A shared Horner-step helper is not worth extracting at this size.

Test Plan:
- CUBIC=1, c={c0=1,c1=2,c2=3,c3=4}, r=2, en 0->1 -> val_out=49, ready_pulse exactly once, ready low throughout evaluation.
- Same c, r=p-1 (i.e. -1) -> val_out = p-2; r=0 -> val_out=1; r=1 -> val_out=10.
- CUBIC=0, c={5,0,1,99}, r=3 -> val_out=14 (c3 ignored); latency equals quadratic formula.
- Change c_in/r_in and pulse en mid-evaluation -> result unaffected, no second run. en held high at reset release -> no start.
- Assert rstb low during MUL2 -> val_out=0, ready=1 asynchronously. A new start after release yields correct 49 for the first case.
- With EVAL_SUM_CHECK_EN, c={1,2,3,4}: claim_in=11 -> check_ok=1; claim_in=12 -> check_ok=0; val_out still correct.
